// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative multiply, divide and shifts.
// Results and flags are registered and framed by a start/busy/done handshake.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       mode,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             cout,
    output logic             zout,
    output logic             nout,
    output logic             busy,
    output logic             done
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | iterative op in progress, one step per cycle
    // DONE  | results written this cycle, start accepted again
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_SHL, OP_SHR} op_t;

    state_t           state;
    op_t              op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, acc_hi, acc_lo;
    logic             sbit;

    logic [WIDTH:0]   sum;
    logic [LW:0]      shamt;
    logic             iter, cmp;
    logic [WIDTH-1:0] s_out, s_hi;
    logic             s_c, s_z, s_n;
    logic [CW-1:0]    s_cnt;
    op_t              s_op;

    always_comb begin
        s_out = '0;
        s_hi  = '0;
        s_c   = cin;
        iter  = 1'b0;
        cmp   = 1'b0;
        s_cnt = CW'(WIDTH);
        s_op  = OP_MUL;
        sum   = '0;
        shamt = dataB[LW:0];
        case (mode)
            5'h00: s_out = dataB;
            5'h01: s_out = dataA & dataB;
            5'h02: s_out = dataA | dataB;
            5'h03: s_out = dataA ^ dataB;
            5'h0E: s_out = dataA;
            5'h0A: s_out = ~dataA;
            5'h04: begin
                sum = {1'b0, dataA} + {1'b0, dataB};
                {s_c, s_out} = sum;
            end
            5'h05: begin
                sum = {1'b0, dataA} + {1'b0, dataB} + {{WIDTH{1'b0}}, cin};
                {s_c, s_out} = sum;
            end
            5'h07: begin
                sum = {1'b0, dataA} - {1'b0, dataB};
                {s_c, s_out} = sum;
            end
            5'h08: begin
                sum = {1'b0, dataA} - {1'b0, dataB} - {{WIDTH{1'b0}}, cin};
                {s_c, s_out} = sum;
            end
            5'h06: begin
                s_out = dataA;
                s_c   = dataA < dataB;
                cmp   = 1'b1;
            end
            5'h0B: {s_c, s_out} = {dataA, 1'b0};
            5'h0C: begin
                s_out = {1'b0, dataA[WIDTH-1:1]};
                s_c   = dataA[0];
            end
            5'h0D: begin
                s_out = {dataA[WIDTH-1], dataA[WIDTH-1:1]};
                s_c   = dataA[0];
            end
            5'h10: iter = 1'b1;
            5'h11: begin
                if (dataB == '0) begin
                    s_out = '1;
                    s_hi  = dataA;
                    s_c   = 1'b1;
                end else begin
                    iter = 1'b1;
                    s_op = OP_DIV;
                end
            end
            5'h12, 5'h13: begin
                if (shamt == '0) begin
                    s_out = dataA;
                end else begin
                    iter  = 1'b1;
                    s_op  = mode[0] ? OP_SHR : OP_SHL;
                    s_cnt = CW'(shamt);
                end
            end
            default: s_out = '0;
        endcase
        s_z = cmp ? (dataA == dataB) : (s_out == '0 && s_hi == '0);
        s_n = cmp ? (dataA > dataB) : s_out[WIDTH-1];
    end

    logic [WIDTH:0]   m_sum, d_rsh;
    logic [WIDTH-1:0] d_trial, n_hi, n_lo;
    logic             d_ge, n_bit, r_c;

    // One step of the active iterative op; results are taken from these on the last step.
    always_comb begin
        n_hi    = acc_hi;
        n_lo    = acc_lo;
        n_bit   = sbit;
        m_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_r} : '0);
        d_rsh   = {acc_hi, acc_lo[WIDTH-1]};
        d_ge    = d_rsh >= {1'b0, b_r};
        d_trial = d_rsh[WIDTH-1:0] - b_r;
        case (op_r)
            OP_MUL: begin
                n_hi = m_sum[WIDTH:1];
                n_lo = {m_sum[0], acc_lo[WIDTH-1:1]};
            end
            OP_DIV: begin
                n_hi = d_ge ? d_trial : d_rsh[WIDTH-1:0];
                n_lo = {acc_lo[WIDTH-2:0], d_ge};
            end
            OP_SHL: begin
                n_lo  = {acc_lo[WIDTH-2:0], 1'b0};
                n_bit = acc_lo[WIDTH-1];
            end
            OP_SHR: begin
                n_lo  = {1'b0, acc_lo[WIDTH-1:1]};
                n_bit = acc_lo[0];
            end
            default: n_lo = acc_lo;
        endcase
        r_c = (op_r == OP_MUL) ? (n_hi != '0) : (op_r == OP_DIV) ? 1'b0 : n_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            op_r   <= OP_MUL;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            sbit   <= 1'b0;
            out    <= '0;
            out_hi <= '0;
            cout   <= 1'b0;
            zout   <= 1'b0;
            nout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (iter) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            op_r   <= s_op;
                            cnt    <= s_cnt;
                            a_r    <= dataA;
                            b_r    <= dataB;
                            acc_hi <= '0;
                            acc_lo <= (s_op == OP_MUL) ? dataB : dataA;
                            sbit   <= 1'b0;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            out    <= s_out;
                            out_hi <= s_hi;
                            cout   <= s_c;
                            zout   <= s_z;
                            nout   <= s_n;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= n_hi;
                    acc_lo <= n_lo;
                    sbit   <= n_bit;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        out    <= n_lo;
                        out_hi <= n_hi;
                        cout   <= r_c;
                        zout   <= (n_lo == '0) && (n_hi == '0);
                        nout   <= n_lo[WIDTH-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
